// File: rtl/serial_loader.sv
// serial_loader
//
// Parallel-to-serial front end for the serial run-length detector. Words are
// accepted over a valid/ready handshake into a one-word holding buffer. They
// are then shifted out one bit per clock. When the buffer is refilled early
// enough, consecutive words leave with no idle cycle between them.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   din        parallel input word (WIDTH bits)
//   din_valid  din carries a word
//   din_ready  holding buffer is empty and can take a word
//   ostream    serial output bit (IDLE_BIT when no word is being sent)
//   ovalid     ostream carries a data bit this cycle
//   sof        current bit is the first bit of a word
//   eof        current bit is the last bit of a word
//   busy       shifting, or a word is waiting in the holding buffer
module serial_loader #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ostream,
  output logic             ovalid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;

  logic at_last;
  logic accept;
  logic load;

  assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign accept  = din_valid && !hold_full_q;
  // A held word moves into the shift register either straight away from
  // idle, or on the edge that retires the last bit of the current word, so
  // back-to-back words leave without a gap.
  assign load    = hold_full_q && ((state_q == IDLE) || at_last);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;

    // accept and load are mutually exclusive: accept needs an empty buffer,
    // load needs a full one.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    if (load) begin
      shreg_d     = hold_q;
      cnt_d       = '0;
      state_d     = SHIFT;
      hold_full_d = 1'b0;
    end else if (state_q == SHIFT) begin
      if (LSB_FIRST) begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end else begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
    end
  end

  // Outputs are decoded from registers only; din never reaches them.
  assign din_ready = !hold_full_q;
  assign ovalid    = (state_q == SHIFT);
  assign ostream   = (state_q == SHIFT) ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1])
                                        : IDLE_BIT;
  assign sof       = (state_q == SHIFT) && (cnt_q == '0);
  assign eof       = at_last;
  assign busy      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader
//
// Bench for serial_loader. Instance dut_a uses the default parameters
// (LSB first, idle level 0) and is checked against a scoreboard of expected
// serial bits. Each bit is tagged with the clock edge after which it must
// appear. Instance dut_b (MSB first, idle level 1) is checked with directed
// steps.
module tb_serial_loader;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;

  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, ostream, ovalid, sof, eof, busy;

  logic [W-1:0] din_b;
  logic         din_valid_b;
  logic         din_ready_b, ostream_b, ovalid_b, sof_b, eof_b, busy_b;

  serial_loader #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ostream   (ostream),
    .ovalid    (ovalid),
    .sof       (sof),
    .eof       (eof),
    .busy      (busy)
  );

  serial_loader #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din_b),
    .din_valid (din_valid_b),
    .din_ready (din_ready_b),
    .ostream   (ostream_b),
    .ovalid    (ovalid_b),
    .sof       (sof_b),
    .eof       (eof_b),
    .busy      (busy_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the bench itself wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    int   edge_no;
    int   idx;
    logic b;
    logic s;
    logic e;
  } exp_t;

  exp_t q[$];
  int   cmp_count = 0;
  int   err_count = 0;
  int   cyc = 0;
  int   last_end = -100;
  int   m_load_edge = 0;
  bit   m_hold = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_count++;
    assert (obs === expv) else begin
      err_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compares dut_a against the scoreboard for the edge just taken.
  task automatic checkOutput();
    bit in_shift;
    in_shift = (q.size() > 0) && (q[0].edge_no == cyc);
    checkVal("din_ready", {31'd0, din_ready}, {31'd0, !m_hold});
    checkVal("busy", {31'd0, busy}, {31'd0, (m_hold || in_shift)});
    checkVal("ovalid", {31'd0, ovalid}, {31'd0, in_shift});
    if (in_shift) begin
      checkVal($sformatf("ostream bit%0d", q[0].idx), {31'd0, ostream}, {31'd0, q[0].b});
      checkVal($sformatf("sof bit%0d", q[0].idx), {31'd0, sof}, {31'd0, q[0].s});
      checkVal($sformatf("eof bit%0d", q[0].idx), {31'd0, eof}, {31'd0, q[0].e});
      void'(q.pop_front());
    end else begin
      checkVal("idle ostream", {31'd0, ostream}, 32'd0);
      checkVal("idle sof", {31'd0, sof}, 32'd0);
      checkVal("idle eof", {31'd0, eof}, 32'd0);
    end
  endtask

  // Drives dut_a for one edge, updates the reference model, then checks.
  // A word accepted on edge c starts after edge max(c+1, end of previous
  // word + 1); that same edge is where the held word is loaded.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, output bit acc);
    int start;
    din_valid = v;
    din       = d;
    @(posedge clk);
    cyc++;
    acc = 1'b0;
    if (m_hold) begin
      if (cyc == m_load_edge) m_hold = 1'b0;
    end else if (v) begin
      acc   = 1'b1;
      start = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
      for (int k = 0; k < W; k++) begin
        exp_t e;
        e.edge_no = start + k;
        e.idx     = k;
        e.b       = d[k];
        e.s       = (k == 0);
        e.e       = (k == W - 1);
        q.push_back(e);
      end
      last_end    = start + W - 1;
      m_hold      = 1'b1;
      m_load_edge = start;
    end
    #1;
    checkOutput();
  endtask

  task automatic sendWord(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) applyStimulus(1'b1, d, acc);
    if (!acc) checkVal("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 60 && (q.size() > 0 || m_hold); i++) applyStimulus(1'b0, '0, acc);
    checkVal("drain timeout", q.size(), 32'd0);
    applyStimulus(1'b0, '0, acc);
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, " ostream"}, {31'd0, ostream}, 32'd0);
    checkVal({tag, " ovalid"}, {31'd0, ovalid}, 32'd0);
    checkVal({tag, " sof"}, {31'd0, sof}, 32'd0);
    checkVal({tag, " eof"}, {31'd0, eof}, 32'd0);
    checkVal({tag, " busy"}, {31'd0, busy}, 32'd0);
    checkVal({tag, " din_ready"}, {31'd0, din_ready}, 32'd1);
    checkVal({tag, " b ostream"}, {31'd0, ostream_b}, 32'd1);
    checkVal({tag, " b ovalid"}, {31'd0, ovalid_b}, 32'd0);
    checkVal({tag, " b din_ready"}, {31'd0, din_ready_b}, 32'd1);
  endtask

  initial begin
    bit acc;

    // Reset values with random inputs toggling underneath.
    rst_n       = 1'b0;
    din         = 16'($urandom);
    din_valid   = 1'b1;
    din_b       = 16'($urandom);
    din_valid_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      din         = 16'($urandom);
      din_b       = 16'($urandom);
      din_valid   = 1'($urandom);
      din_valid_b = 1'($urandom);
    end
    #1;
    checkResetValues("reset");
    din_valid   = 1'b0;
    din_valid_b = 1'b0;
    #2;
    rst_n = 1'b1;

    // Single word on the first edge after reset release.
    sendWord(16'b1101111110101110);
    drain();

    // Back-to-back words with din_valid held high.
    sendWord(16'hFFFF);
    sendWord(16'h0000);
    drain();

    // Backpressure: din changes every cycle while valid stays high; only
    // the value on each accepting edge enters the scoreboard.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'($urandom), acc);
    drain();

    // MSB first with idle level 1 on dut_b.
    checkVal("b idle before ostream", {31'd0, ostream_b}, 32'd1);
    din_b       = 16'hC000;
    din_valid_b = 1'b1;
    applyStimulus(1'b0, '0, acc);
    din_valid_b = 1'b0;
    checkVal("b latency ovalid", {31'd0, ovalid_b}, 32'd0);
    checkVal("b held busy", {31'd0, busy_b}, 32'd1);
    for (int k = 0; k < W; k++) begin
      applyStimulus(1'b0, '0, acc);
      checkVal($sformatf("b ovalid bit%0d", k), {31'd0, ovalid_b}, 32'd1);
      checkVal($sformatf("b ostream bit%0d", k), {31'd0, ostream_b}, {31'd0, (k < 2)});
      checkVal($sformatf("b sof bit%0d", k), {31'd0, sof_b}, {31'd0, (k == 0)});
      checkVal($sformatf("b eof bit%0d", k), {31'd0, eof_b}, {31'd0, (k == W - 1)});
    end
    applyStimulus(1'b0, '0, acc);
    checkVal("b idle after ovalid", {31'd0, ovalid_b}, 32'd0);
    checkVal("b idle after ostream", {31'd0, ostream_b}, 32'd1);
    checkVal("b idle after busy", {31'd0, busy_b}, 32'd0);

    // Reset in the middle of a word: pulse rst_n while bit 7 is on the line.
    sendWord(16'hAAAA);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, '0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    q.delete();
    m_hold   = 1'b0;
    last_end = -100;
    #2;
    rst_n = 1'b1;
    sendWord(16'h000F);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/serial_loader.md
# serial_loader

Parallel-to-serial front end that feeds the serial run-length detector's `istream` input. It accepts `WIDTH`-bit words over a valid/ready handshake and buffers one word. It then shifts the words out one bit per `clk` cycle, gap-free when words arrive back-to-back. Framing strobes (`sof`, `eof`, `ovalid`) let downstream logic and benches align detector output to word boundaries.

## Interface

Parameters:
- `WIDTH`, default 16: word length in bits; minimum 2.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit `WIDTH-1` first.
- `IDLE_BIT`, default 0: level driven on `ostream` when no word is being sent.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `din`  input  WIDTH  parallel word.
- `din_valid`  input  1  `din` is valid.
- `din_ready`  output  1  holding buffer can take a word.
- `ostream`  output  1  serial bit; connects to the detector's `istream`.
- `ovalid`  output  1  `ostream` carries a data bit this cycle.
- `sof`  output  1  current bit is the first of a word.
- `eof`  output  1  current bit is the last of a word.
- `busy`  output  1  shifting, or a word is held.

## Operation

**Storage**
- Holding register `hold[WIDTH-1:0]` with flag `hold_full`.
- Shift register `shreg[WIDTH-1:0]`.
- Bit counter `cnt`, width `$clog2(WIDTH)`, range 0..`WIDTH-1`.
- FSM states: `IDLE`, `SHIFT`.

**Handshake**
- `din_ready = !hold_full`.
- Accept occurs on an edge where `din_valid && din_ready`: `hold <= din`, `hold_full <= 1`.
- While `din_ready = 0`, `din` is ignored, even if it changes.

**Load**
- A load occurs on an edge where `hold_full` is 1 and either the state is `IDLE`, or the state is `SHIFT` with `cnt == WIDTH-1`.
- On load: `shreg <= hold`, `cnt <= 0`, state `<= SHIFT`, `hold_full <= 0`.
- Accept and load can coincide on one edge only if `hold_full` was 0, so no load occurs on that edge. When `hold_full` is 1, `din_ready` is 0.

**Shifting in `SHIFT`**
- Each edge without a load shifts `shreg` toward the output end and increments `cnt`.
- At `cnt == WIDTH-1` with `hold_full == 0`, the next edge moves the state to `IDLE` and clears `cnt`.

**Outputs (decoded from registers only, no `din` path)**
- `ostream`: `shreg[0]` if `LSB_FIRST`, else `shreg[WIDTH-1]`, while in `SHIFT`. `IDLE_BIT` in `IDLE`.
- `ovalid`: 1 exactly when state is `SHIFT`.
- `sof`: `SHIFT && cnt == 0`.
- `eof`: `SHIFT && cnt == WIDTH-1`.
- `busy`: `SHIFT || hold_full`.

**Reset (`rst_n` low, immediate, asynchronous)**
- State `IDLE`, `cnt = 0`, `hold_full = 0`, `shreg = 0`, `hold = 0`.
- Output values: `ostream = IDLE_BIT`, `ovalid = 0`, `sof = 0`, `eof = 0`, `busy = 0`, `din_ready = 1`.
- Reset mid-word discards both the in-flight word and the held word. No partial word resumes after reset.

## Timing

- Latency: an accept on edge E0 puts bit 0 on `ostream` after E1. Bit `k` is valid in the cycle after edge E1+k.
- Throughput: one bit per cycle. With `din_valid` held high, words stream with zero idle cycles between `eof` and the next `sof`.
- Buffer refill: after a load, `din_ready` rises for the following cycle. Because `WIDTH >= 2`, the next word can be accepted before `eof`.
- The first edge after `rst_n` deasserts may accept a word.

## Test plan

1. **Reset values.** Assert `rst_n = 0` with random inputs -> `ostream = 0`, `ovalid = 0`, `sof = 0`, `eof = 0`, `busy = 0`, `din_ready = 1`.
2. **Single word.** Accept `16'b1101111110101110` at E0 -> after E1..E16, `ostream` = 0,1,1,1,0,1,0,1,1,1,1,1,1,0,1,1. `sof` is 1 on the first bit only, `eof` on the last bit only. After E17: `ovalid = 0`, `busy = 0`.
3. **Back-to-back.** Present `16'hFFFF` then `16'h0000` with `din_valid` continuously high -> 32 consecutive `ovalid` cycles: 16 ones then 16 zeros. `sof` appears at cycles 1 and 17, `eof` at cycles 16 and 32. `din_ready` is low while a word is held.
4. **Backpressure.** While `hold_full`, change `din` every cycle with `din_valid = 1` -> `din_ready = 0`. Only the value present on the accepting edge is serialized.
5. **MSB first.** With `LSB_FIRST = 0` and `IDLE_BIT = 1`, send `16'hC000` -> `ostream` = 1,1 then 14 zeros, and `ostream = 1` in idle cycles before and after.
6. **Reset mid-word.** Pulse `rst_n` low during bit 7 of `16'hAAAA` -> outputs take reset values immediately. Then `16'h000F` sent after release -> emits 1,1,1,1 followed by 12 zeros, starting at bit 0 with `sof`.
